// File: rtl/ov5640_cfg_seq.sv
// OV5640 power-up and register-table sequencer: times the PWDN/RESET pins, then
// walks a synchronous ROM and issues one SCCB write per entry to an I2C master.
module ov5640_cfg_seq #(
  parameter int          LUT_SIZE    = 256,
  parameter int          LUT_AW      = 8,
  parameter logic [7:0]  DEV_ADDR    = 8'h78,
  parameter logic [31:0] PWDN_CYCLES = 32'd500000,
  parameter logic [31:0] RST_CYCLES  = 32'd100000,
  parameter logic [31:0] INIT_CYCLES = 32'd1000000,
  parameter logic [31:0] DELAY_UNIT  = 32'd50000,
  parameter int          MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [LUT_AW-1:0] lut_index,
  input  logic [23:0]       lut_data,
  output logic [7:0]        i2c_slave_addr,
  output logic              i2c_write_req,
  output logic [15:0]       i2c_addr,
  output logic [7:0]        i2c_data,
  input  logic              i2c_write_ack,
  input  logic              i2c_error,
  output logic              cmos_pwdn,
  output logic              cmos_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PWDN   = 4'd1;
  localparam logic [3:0] S_RST    = 4'd2;
  localparam logic [3:0] S_INIT   = 4'd3;
  localparam logic [3:0] S_FETCH  = 4'd4;
  localparam logic [3:0] S_DECODE = 4'd5;
  localparam logic [3:0] S_WRITE  = 4'd6;
  localparam logic [3:0] S_RETRY  = 4'd7;
  localparam logic [3:0] S_DELAY  = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_ERROR  = 4'd10;

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ONE = RW'(1);
  // One extra index bit so the table end (index == LUT_SIZE) is representable.
  localparam logic [LUT_AW:0] IDX_END = (LUT_AW+1)'(LUT_SIZE);
  localparam logic [LUT_AW:0] IDX_ONE = (LUT_AW+1)'(1);

  logic [3:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [LUT_AW:0]   idx_q, idx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              req_q, req_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              pwdn_q, pwdn_d;
  logic              rst_n_q, rst_n_d;
  logic              cnt_expire;
  logic [31:0]       dly_cycles;

  // A loaded count of 0 or 1 both expire after a single cycle.
  assign cnt_expire = (cnt_q <= 32'd1);
  assign dly_cycles = {24'd0, lut_data[7:0]} * DELAY_UNIT;

  // Handshake: req rises with addr/data stable and holds until the cycle an ack
  // pulse is seen (error qualified by ack); req is low the cycle after every ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pwdn_d  = pwdn_q;
    rst_n_d = rst_n_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_PWDN;
          cnt_d   = PWDN_CYCLES;
          idx_d   = '0;
          retry_d = '0;
          pwdn_d  = 1'b1;
          rst_n_d = 1'b0;
        end
      end
      S_PWDN: begin
        if (cnt_expire) begin
          pwdn_d  = 1'b0;
          cnt_d   = RST_CYCLES;
          state_d = S_RST;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RST: begin
        if (cnt_expire) begin
          rst_n_d = 1'b1;
          cnt_d   = INIT_CYCLES;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_INIT: begin
        if (cnt_expire) state_d = S_FETCH;
        else            cnt_d   = cnt_q - 32'd1;
      end
      S_FETCH: begin
        // This cycle covers the ROM read latency for the current index.
        if (idx_q == IDX_END) state_d = S_DONE;
        else                  state_d = S_DECODE;
      end
      S_DECODE: begin
        if (lut_data[23:8] == 16'hFFFF) begin
          cnt_d   = dly_cycles;
          state_d = S_DELAY;
        end else if (lut_data[23:8] == 16'hFFFE) begin
          state_d = S_DONE;
        end else begin
          addr_d  = lut_data[23:8];
          data_d  = lut_data[7:0];
          req_d   = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i2c_write_ack) begin
          req_d = 1'b0;
          if (!i2c_error) begin
            idx_d   = idx_q + IDX_ONE;
            retry_d = '0;
            state_d = S_FETCH;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_ONE;
            state_d = S_RETRY;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_RETRY: begin
        req_d   = 1'b1;
        state_d = S_WRITE;
      end
      S_DELAY: begin
        if (cnt_expire) begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pwdn_q  <= 1'b1;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pwdn_q  <= pwdn_d;
      rst_n_q <= rst_n_d;
    end
  end

  assign lut_index      = idx_q[LUT_AW-1:0];
  assign i2c_slave_addr = DEV_ADDR;
  assign i2c_write_req  = req_q;
  assign i2c_addr       = addr_q;
  assign i2c_data       = data_q;
  assign cmos_pwdn      = pwdn_q;
  assign cmos_rst_n     = rst_n_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERROR);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Bench for ov5640_cfg_seq: random tables and error patterns scored against a
// table-walking timing model; an I2C responder acks after a programmable latency.
module tb_ov5640_cfg_seq;

  localparam int NE   = 3;
  localparam int P    = 4;
  localparam int R    = 3;
  localparam int I    = 5;
  localparam int U    = 10;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        rst, start, ack, err;
  logic [23:0] lut_data;
  logic [7:0]  lut_index, slave_addr, i2c_data;
  logic        req;
  logic [15:0] i2c_addr;
  logic        pwdn, rst_n, busy, done, error;
  logic [3:0]  dbg_state;

  ov5640_cfg_seq #(
    .LUT_SIZE(NE), .LUT_AW(8), .DEV_ADDR(8'h78),
    .PWDN_CYCLES(32'(P)), .RST_CYCLES(32'(R)), .INIT_CYCLES(32'(I)),
    .DELAY_UNIT(32'(U)), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
    .i2c_slave_addr(slave_addr), .i2c_write_req(req), .i2c_addr(i2c_addr),
    .i2c_data(i2c_data), .i2c_write_ack(ack), .i2c_error(err), .cmos_pwdn(pwdn),
    .cmos_rst_n(rst_n), .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / cycle counter / ROM
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] tbl [NE];
  int          errs [NE];
  always @(posedge clk)
    lut_data <= (int'(lut_index) < NE) ? tbl[lut_index[1:0]] : 24'h0;

  // scoreboard state
  logic [23:0] exp_q [$];
  bit          err_q [$];
  int          rise_q [$];
  int          ack_q [$];
  int checks = 0, errors = 0;
  int start_cyc = 0, ack_lat = 1, stray_rel = -100;
  int pwdn_low_rel = -1, rstn_high_rel = -1;
  bit prev_ack_err = 0;
  bit exp_done;
  int exp_idx, exp_time, exp_writes, last_fin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: walks the table by the sequencing rules and predicts the
  // write attempts, the per-ack error responses, the outcome and its cycle.
  task automatic build_model(input int a);
    int t, n;
    bit stop, ok;
    logic [15:0] ra;
    logic [7:0] rd;
    exp_q.delete(); err_q.delete();
    t = P + R + I; exp_done = 1; exp_idx = NE; exp_writes = 0; stop = 0;
    for (int i = 0; i < NE && !stop; i++) begin
      ra = tbl[i][23:8];
      rd = tbl[i][7:0];
      if (ra == 16'hFFFE) begin
        t += 2; exp_idx = i; stop = 1;
      end else if (ra == 16'hFFFF) begin
        n = int'(rd) * U;
        if (n == 0) n = 1;
        t += 2 + n;
      end else begin
        t += 2; ok = 0;
        for (int k = 0; k <= MAXR && !ok; k++) begin
          exp_q.push_back(tbl[i]);
          err_q.push_back(k < errs[i]);
          exp_writes++;
          t += (k == 0) ? a : 1 + a;
          if (k >= errs[i]) ok = 1;
        end
        if (!ok) begin exp_done = 0; exp_idx = i; stop = 1; end
      end
    end
    if (!stop) t += 1;
    exp_time = t;
  endtask

  // I2C responder and write monitor, sampling on the falling edge
  initial begin
    int hi_cnt, last_ack_rel, rel;
    bit req_prev, ack_was, ack_now;
    logic [23:0] cur;
    hi_cnt = 0; last_ack_rel = 0; req_prev = 0; ack_was = 0; cur = '0;
    ack = 0; err = 0;
    forever begin
      @(negedge clk);
      rel = cyc - start_cyc;
      ack_now = 0;
      ack = 0; err = 0;
      if (rst) begin
        req_prev = 0; hi_cnt = 0;
      end else begin
        if (rel >= 0 && !pwdn && pwdn_low_rel < 0) pwdn_low_rel = rel;
        if (rel >= 0 && rst_n && rstn_high_rel < 0) rstn_high_rel = rel;
        if (ack_was) check("req_drop_after_ack", req, 0);
        if (req && !req_prev) begin
          rise_q.push_back(rel);
          hi_cnt = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 1, 0);
            cur = {i2c_addr, i2c_data};
          end else begin
            cur = exp_q.pop_front();
            check("wr_addr", i2c_addr, cur[23:8]);
            check("wr_data", i2c_data, cur[7:0]);
          end
          if (prev_ack_err) check("retry_gap", rel - last_ack_rel, 2);
        end
        if (req) begin
          hi_cnt++;
          if (hi_cnt == ack_lat) begin
            check("wr_hold", {i2c_addr, i2c_data}, cur);
            ack = 1;
            err = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
            ack_now = 1; last_ack_rel = rel; prev_ack_err = err;
            ack_q.push_back(rel);
          end
        end else if (rel == stray_rel) begin
          ack = 1; err = 1'($urandom_range(0, 1));
        end
        req_prev = req;
      end
      ack_was = ack_now;
    end
  end

  task automatic gen_tbl(input bit special);
    int k;
    for (int i = 0; i < NE; i++) begin
      k = special ? $urandom_range(0, 9) : 9;
      if (k == 0)      tbl[i] = {16'hFFFE, 8'($urandom_range(0, 255))};
      else if (k <= 2) tbl[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
      else             tbl[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom_range(0, 255))};
      k = $urandom_range(0, 7);
      errs[i] = special ? ((k < 5) ? 0 : k - 3) : 0;
    end
  endtask

  task automatic run_seq(input int a, input bit stray);
    int n;
    build_model(a);
    ack_lat = a; rise_q.delete(); ack_q.delete(); prev_ack_err = 0;
    @(negedge clk);
    pwdn_low_rel = -1; rstn_high_rel = -1;
    start_cyc = cyc + 1; start = 1;
    @(negedge clk);
    start = 0;
    check("start_pwdn", pwdn, 1);
    check("start_rstn", rst_n, 0);
    check("start_index", lut_index, 0);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_error", error, 0);
    if (stray) begin
      stray_rel = 2;
      while (cyc - start_cyc < P + R + 1) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      check("start_while_busy", busy, 1);
    end
    n = 0;
    while (!(done || error) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    last_fin = cyc - start_cyc;
    check("finish_reached", done | error, 1);
    check("end_done", done, exp_done);
    check("end_error", error, !exp_done);
    check("end_busy", busy, 0);
    check("end_index", lut_index, exp_idx);
    check("end_time", last_fin, exp_time);
    check("end_pwdn", pwdn, 0);
    check("end_rstn", rst_n, 1);
    check("pwdn_fall", pwdn_low_rel, P);
    check("rstn_rise", rstn_high_rel, P + R);
    check("write_count", rise_q.size(), exp_writes);
    check("exp_left", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("hold_done", done, exp_done);
    check("hold_index", lut_index, exp_idx);
    stray_rel = -100;
  endtask

  initial begin
    int n;
    rst = 1; start = 0;
    for (int i = 0; i < NE; i++) begin tbl[i] = '0; errs[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_req", req, 0);
    check("rst_addr", i2c_addr, 0);
    check("rst_data", i2c_data, 0);
    check("rst_pwdn", pwdn, 1);
    check("rst_rstn", rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_index", lut_index, 0);
    check("slave_addr", slave_addr, 8'h78);

    // directed table with end marker, ack latency 10
    tbl[0] = 24'h3008_82; tbl[1] = 24'h3103_03; tbl[2] = 24'hFFFE_00;
    run_seq(10, 0);
    check("first_req_cycle", (rise_q.size() > 0) ? rise_q[0] : -1, P + R + I + 2);
    check("done_after_marker", last_fin - ((ack_q.size() > 1) ? ack_q[1] : 0), 3);

    // three plain entries, table end by size
    gen_tbl(0);
    run_seq($urandom_range(1, 6), 0);
    check("done_after_last_ack", last_fin - ((ack_q.size() > 2) ? ack_q[2] : 0), 2);

    // delay entry of 5 units
    gen_tbl(0);
    tbl[1] = 24'hFFFF_05;
    run_seq($urandom_range(1, 6), 0);
    check("delay_gap", ((rise_q.size() > 1) ? rise_q[1] : 0) - ((ack_q.size() > 0) ? ack_q[0] : 0),
          5 * U + 5);

    // two errors on entry 1, then success
    gen_tbl(0);
    errs[1] = 2;
    run_seq($urandom_range(1, 6), 0);

    // entry 2 never succeeds
    gen_tbl(0);
    errs[2] = 4;
    run_seq($urandom_range(1, 6), 0);

    // restart from ERROR, with a stray ack and a start while busy
    gen_tbl(0);
    run_seq($urandom_range(1, 6), 1);

    // reset in the middle of a write
    gen_tbl(0);
    build_model(50);
    ack_lat = 50; prev_ack_err = 0;
    @(negedge clk);
    start_cyc = cyc + 1; start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!req && n < 200) begin @(negedge clk); n++; end
    check("mid_req_seen", req, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    check("busy_start_req", req, 1);
    check("busy_start_index", lut_index, 0);
    rst = 1;
    @(negedge clk);
    check("midrst_req", req, 0);
    check("midrst_pwdn", pwdn, 1);
    check("midrst_rstn", rst_n, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_addr", i2c_addr, 0);
    rst = 0;
    @(negedge clk);

    // randomized tables with special entries and error patterns
    for (int r = 0; r < 8; r++) begin
      gen_tbl(1);
      run_seq($urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
